// File: rtl/ahb_slave_controller.sv
// AHB-Lite slave transfer sequencer: qualifies address phases, holds the data-phase
// controls, inserts backend wait states and issues the two-cycle ERROR response.
module ahb_slave_controller #(
  parameter int ADDR_W     = 32,
  parameter int MAX_SIZE   = 4,
  parameter int WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HREADY,
  input  logic              backend_ready,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic              size_enable,
  output logic [2:0]        size_sel,
  output logic [ADDR_W-1:0] addr_q,
  output logic              wr_strobe,
  output logic              rd_strobe
);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [2:0] MAX_SZ = 3'(MAX_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              write_q;
  logic              accept;
  logic              can_accept;
  logic              take;
  logic              bad;
  logic [ADDR_W-1:0] size_mask;
  logic              unused_htrans0;

  // Only the NONSEQ/SEQ distinction from IDLE/BUSY matters here.
  assign unused_htrans0 = HTRANS[0];

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign can_accept = (state == IDLE) || (state == ERR2) || ((state == DATA) && backend_ready);
  assign take       = accept & can_accept;

  always_comb begin
    size_mask = ({{(ADDR_W-1){1'b0}}, 1'b1} << HSIZE) - {{(ADDR_W-1){1'b0}}, 1'b1};
    bad       = (HSIZE > MAX_SZ) || ((HADDR & size_mask) != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      size_sel <= '0;
      write_q  <= 1'b0;
    end else begin
      if (take) begin
        addr_q   <= HADDR;
        size_sel <= HSIZE;
        write_q  <= HWRITE;
      end
      case (state)
        IDLE, ERR2: begin
          wait_cnt <= '0;
          if (take) state <= bad ? ERR1 : DATA;
          else      state <= IDLE;
        end
        DATA: begin
          if (backend_ready) begin
            wait_cnt <= '0;
            if (take) state <= bad ? ERR1 : DATA;
            else      state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            // Backend never answered: abandon the access and report ERROR.
            wait_cnt <= '0;
            state    <= ERR1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ERR1: begin
          wait_cnt <= '0;
          state    <= ERR2;
        end
        default: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    HREADYOUT   = (state == DATA) ? backend_ready : (state != ERR1);
    HRESP       = (state == ERR1) || (state == ERR2);
    size_enable = (state == DATA);
    wr_strobe   = (state == DATA) && write_q;
    rd_strobe   = (state == DATA) && !write_q;
  end

endmodule

// File: tb/tb_ahb_slave_controller.sv
// Randomised bench for ahb_slave_controller: a transaction-level model predicts each
// cycle's response from the transfer's size, address and backend latency.
module tb_ahb_slave_controller;

  localparam int AW = 32;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          HSEL, HWRITE, HREADY, backend_ready;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic [AW-1:0] HADDR;
  logic          HREADYOUT, HRESP, size_enable, wr_strobe, rd_strobe;
  logic [2:0]    size_sel;
  logic [AW-1:0] addr_q;
  logic [4:0]    outs;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  assign outs = {HREADYOUT, HRESP, size_enable, wr_strobe, rd_strobe};

  ahb_slave_controller #(.ADDR_W(AW), .MAX_SIZE(4), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .n_rst(n_rst), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HADDR(HADDR), .HREADY(HREADY), .backend_ready(backend_ready),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .size_enable(size_enable),
    .size_sel(size_sel), .addr_q(addr_q), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic idle_inputs();
    HSEL          = $urandom_range(0, 1);
    HTRANS        = 2'($urandom_range(0, 1));
    HWRITE        = $urandom_range(0, 1);
    HSIZE         = 3'($urandom_range(0, 7));
    HADDR         = $urandom;
    HREADY        = 1'b1;
    backend_ready = $urandom_range(0, 1);
  endtask

  // One complete transfer started from IDLE; the bus is idle (or a forced, ignored
  // address phase is shown) during the data/error cycles.
  task automatic xfer(input bit w, input bit [2:0] sz, input logic [AW-1:0] a, input int waits);
    bit    bad, tmo;
    int    n;
    string res;
    bad = (sz > 3'd4) || ((a % (32'd1 << sz)) != 0);
    tmo = !bad && (waits >= WL);
    n   = tmo ? WL : waits + 1;

    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HSIZE = sz; HADDR = a; HREADY = 1'b1;
    backend_ready = $urandom_range(0, 1);
    @(negedge clk);
    check("addr_phase", 64'(outs), 64'(5'b10000));

    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        idle_inputs();
        if (i != waits && $urandom_range(0, 1) == 1) begin
          HSEL = 1'b1; HTRANS = 2'b11; HREADY = 1'b1;
        end else if (i == waits) begin
          HTRANS = 2'b00;
        end
        backend_ready = !tmo && (i == waits);
        @(negedge clk);
        check("data_outs", 64'(outs), 64'({(!tmo && i == waits), 1'b0, 1'b1, w, ~w}));
        check("addr_q", 64'(addr_q), 64'(a));
        check("size_sel", 64'(size_sel), 64'(sz));
      end
    end

    if (bad || tmo) begin
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("err1", 64'(outs), 64'(5'b01000));
      @(posedge clk); #1;
      idle_inputs();
      HSEL = 1'b0;
      @(negedge clk);
      check("err2", 64'(outs), 64'(5'b11000));
    end
    @(posedge clk); #1;
    idle_inputs();
    HSEL = 1'b0;
    res = bad ? "ERROR(illegal)" : (tmo ? "ERROR(timeout)" : "OKAY");
    $display("xfer %s size=%0d addr=%h waits=%0d -> %s", w ? "WR" : "RD", sz, a, waits, res);
  endtask

  task automatic burst3();
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h0; HREADY = 1'b1;
    @(negedge clk);
    check("burst_addr0", 64'(outs), 64'(5'b10000));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        HSEL = 1'b1; HTRANS = 2'b11; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'(4 * k);
      end else begin
        idle_inputs();
        HSEL = 1'b0;
      end
      backend_ready = 1'b1;
      @(negedge clk);
      check("burst_data", 64'(outs), 64'(5'b10110));
      check("burst_addr_q", 64'(addr_q), 64'(4 * (k - 1)));
    end
    @(posedge clk); #1;
    idle_inputs();
    HSEL = 1'b0;
    @(negedge clk);
    check("burst_end", 64'(outs), 64'(5'b10000));
    $display("burst WR x3 at 0x0/0x4/0x8 -> OKAY, no bubble");
  endtask

  task automatic reset_mid_wait();
    @(posedge clk); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h20; HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      HSEL = 1'b0; HTRANS = 2'b00; backend_ready = 1'b0;
      @(negedge clk);
      check("pre_reset_wait", 64'(outs), 64'(5'b00101));
    end
    @(posedge clk); #1;
    n_rst = 1'b0;
    backend_ready = 1'b1;
    #1;
    check("reset_outs", 64'(outs), 64'(5'b10000));
    check("reset_addr_q", 64'(addr_q), 64'(0));
    check("reset_size_sel", 64'(size_sel), 64'(0));
    @(negedge clk);
    check("reset_hold", 64'(outs), 64'(5'b10000));
    @(posedge clk); #1;
    n_rst = 1'b1;
    idle_inputs();
    HSEL = 1'b0;
    $display("reset asserted mid-wait -> outputs at reset values");
  endtask

  initial begin
    idle_inputs();
    HSEL = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", 64'(outs), 64'(5'b10000));
    check("rst_addr_q", 64'(addr_q), 64'(0));
    check("rst_size_sel", 64'(size_sel), 64'(0));
    @(posedge clk); #1;
    n_rst = 1'b1;

    xfer(1'b1, 3'd2, 32'h10, 0);
    xfer(1'b0, 3'd2, 32'h40, 3);
    xfer(1'b1, 3'd5, 32'h0, 0);
    xfer(1'b0, 3'd1, 32'h1, 0);
    xfer(1'b1, 3'd4, 32'h30, 1);
    xfer(1'b0, 3'd4, 32'h38, 0);
    burst3();
    xfer(1'b0, 3'd2, 32'h80, 20);
    xfer(1'b1, 3'd3, 32'h100, WL - 1);
    reset_mid_wait();
    xfer(1'b1, 3'd0, 32'h7, 2);

    for (int t = 0; t < 40; t++) begin
      bit          w;
      bit [2:0]    sz;
      logic [AW-1:0] a;
      w  = $urandom_range(0, 1);
      sz = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      xfer(w, sz, a, $urandom_range(0, 10));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
